heap_move_long: RTL

Multi-cycle heap block-move engine for the generated-program FPGA test harness. Owns the heap memory and per-array size table, and executes `moveLong`-style copies between array areas one element per clock. Generalises the fixed inline copy loop: element width, area size and array count are parametrised, overlapping moves within one array are correct (memmove semantics), a fill mode is added, and out-of-bounds requests are rejected rather than silently written.

---
 rtl/heap_move_long_if.sv | 37 +++
 rtl/heap_move_long.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/heap_move_long_if.sv
// Request, host-port and status signals of the heap block-move engine.
interface heap_move_long_if #(
  parameter int MemoryElementWidth = 12,
  parameter int NArrays            = 8
);
  localparam int AW = $clog2(NArrays);

  logic                          start;
  logic                          mode;
  logic [AW-1:0]                 srcArray;
  logic [AW-1:0]                 tgtArray;
  logic [MemoryElementWidth-1:0] srcOffset;
  logic [MemoryElementWidth-1:0] tgtOffset;
  logic [MemoryElementWidth-1:0] length;
  logic [MemoryElementWidth-1:0] fillValue;
  logic                          hostWe;
  logic [AW-1:0]                 hostArray;
  logic [MemoryElementWidth-1:0] hostIndex;
  logic [MemoryElementWidth-1:0] hostWData;
  logic [MemoryElementWidth-1:0] hostRData;
  logic [MemoryElementWidth-1:0] hostSize;
  logic                          busy;
  logic                          done;
  logic                          error;

  modport master (
    output start, mode, srcArray, tgtArray, srcOffset, tgtOffset, length, fillValue,
    output hostWe, hostArray, hostIndex, hostWData,
    input  hostRData, hostSize, busy, done, error
  );

  modport slave (
    input  start, mode, srcArray, tgtArray, srcOffset, tgtOffset, length, fillValue,
    input  hostWe, hostArray, hostIndex, hostWData,
    output hostRData, hostSize, busy, done, error
  );
endinterface

// File: rtl/heap_move_long.sv
// Heap block-move engine: owns the heap and per-array size table and copies
// (memmove semantics) or fills one element per clock between array areas.
module heap_move_long #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 16,
  parameter int NArrays            = 8
) (
  input logic             clock,
  input logic             reset,
  heap_move_long_if.slave bus
);
  localparam int W     = MemoryElementWidth;
  localparam int AW    = $clog2(NArrays);
  localparam int IW    = $clog2(NArea);
  localparam int HAW   = AW + IW;
  localparam int DEPTH = NArea * NArrays;
  localparam logic [W:0]    AREA_X = (W+1)'(NArea);
  localparam logic [W-1:0]  AREA   = W'(NArea);
  localparam logic [W-1:0]  ONE    = W'(1);
  localparam logic [IW-1:0] K1     = IW'(1);

  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

  state_t        state_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic [W-1:0]  host_rdata_q;
  logic [W-1:0]  host_size_q;
  logic [W-1:0]  sizes_q [NArrays];
  logic [W-1:0]  heap_q  [DEPTH];

  logic          mode_q;
  logic          desc_q;
  logic [AW-1:0] src_arr_q;
  logic [AW-1:0] tgt_arr_q;
  logic [IW-1:0] src_off_q;
  logic [IW-1:0] tgt_off_q;
  logic [IW-1:0] k_q;
  logic [IW-1:0] k_end_q;
  logic [W-1:0]  fill_q;

  // Request decode: end positions carry one extra bit so no sum can wrap past the check.
  logic [W:0]    src_end;
  logic [W:0]    tgt_end;
  logic          req_bad;
  logic          req_desc;
  logic [IW-1:0] len_m1;

  assign src_end  = {1'b0, bus.srcOffset} + {1'b0, bus.length};
  assign tgt_end  = {1'b0, bus.tgtOffset} + {1'b0, bus.length};
  assign req_bad  = (!bus.mode && (src_end > AREA_X)) || (tgt_end > AREA_X);
  assign req_desc = !bus.mode && (bus.srcArray == bus.tgtArray) &&
                    (bus.tgtOffset > bus.srcOffset);
  assign len_m1   = bus.length[IW-1:0] - K1;

  // Active move element addresses and size-table update.
  logic [IW-1:0]  src_idx;
  logic [IW-1:0]  tgt_idx;
  logic [HAW-1:0] src_addr;
  logic [HAW-1:0] tgt_addr;
  logic [W-1:0]   tgt_reach;
  logic [W-1:0]   move_size_d;

  assign src_idx     = src_off_q + k_q;
  assign tgt_idx     = tgt_off_q + k_q;
  assign src_addr    = {src_arr_q, src_idx};
  assign tgt_addr    = {tgt_arr_q, tgt_idx};
  assign tgt_reach   = W'(tgt_off_q) + W'(k_q) + ONE;
  assign move_size_d = (tgt_reach > sizes_q[tgt_arr_q]) ? tgt_reach : sizes_q[tgt_arr_q];

  // Host port: out-of-area indices never touch the heap.
  logic           host_idx_ok;
  logic           host_we;
  logic [HAW-1:0] host_addr;
  logic [W-1:0]   host_reach;
  logic [W-1:0]   host_size_d;

  assign host_idx_ok = bus.hostIndex < AREA;
  assign host_we     = bus.hostWe && !busy_q && host_idx_ok;
  assign host_addr   = {bus.hostArray, bus.hostIndex[IW-1:0]};
  assign host_reach  = bus.hostIndex + ONE;
  assign host_size_d = (host_reach > sizes_q[bus.hostArray]) ? host_reach
                                                             : sizes_q[bus.hostArray];

  // Single heap write port shared by the move engine and the host.
  logic           mem_we;
  logic [HAW-1:0] mem_waddr;
  logic [W-1:0]   mem_wdata;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = host_addr;
    mem_wdata = bus.hostWData;
    if (!reset) begin
      if (state_q == MOVE) begin
        mem_we    = 1'b1;
        mem_waddr = tgt_addr;
        mem_wdata = mode_q ? fill_q : heap_q[src_addr];
      end else if (host_we) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) heap_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      host_rdata_q <= '0;
      host_size_q  <= '0;
      for (int i = 0; i < NArrays; i++) sizes_q[i] <= '0;
    end else begin
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      host_rdata_q <= host_idx_ok ? heap_q[host_addr] : '0;
      host_size_q  <= sizes_q[bus.hostArray];
      if (host_we) sizes_q[bus.hostArray] <= host_size_d;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (req_bad) begin
              error_q <= 1'b1;
            end else if (bus.length == '0) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              mode_q    <= bus.mode;
              desc_q    <= req_desc;
              src_arr_q <= bus.srcArray;
              tgt_arr_q <= bus.tgtArray;
              src_off_q <= bus.srcOffset[IW-1:0];
              tgt_off_q <= bus.tgtOffset[IW-1:0];
              fill_q    <= bus.fillValue;
              k_q       <= req_desc ? len_m1 : '0;
              k_end_q   <= req_desc ? '0 : len_m1;
              busy_q    <= 1'b1;
              state_q   <= MOVE;
            end
          end
        end
        MOVE: begin
          sizes_q[tgt_arr_q] <= move_size_d;
          if (k_q == k_end_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            k_q <= desc_q ? (k_q - K1) : (k_q + K1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.hostRData = host_rdata_q;
  assign bus.hostSize  = host_size_q;
endmodule
